// File: rtl/present_pkg.sv
// Shared constants for the PRESENT-80 accelerator: sizes, round counts and the
// register map of the Avalon-MM front-end.
package present_pkg;

    localparam int KEY_W            = 80;
    localparam int BLOCK_W          = 64;
    localparam int N_ROUNDS         = 31;
    localparam int ROUNDS_PER_CYCLE = 1;

    localparam logic [3:0] REG_CTRL    = 4'd0;
    localparam logic [3:0] REG_STATUS  = 4'd1;
    localparam logic [3:0] REG_PT_LO   = 4'd2;
    localparam logic [3:0] REG_PT_HI   = 4'd3;
    localparam logic [3:0] REG_KEY_LO  = 4'd4;
    localparam logic [3:0] REG_KEY_MID = 4'd5;
    localparam logic [3:0] REG_KEY_HI  = 4'd6;
    localparam logic [3:0] REG_CT_LO   = 4'd7;
    localparam logic [3:0] REG_CT_HI   = 4'd8;
    localparam logic [3:0] REG_ID      = 4'd9;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_IRQ_CLR = 2;

endpackage

// File: rtl/present_avalon_regs.sv
// Avalon-MM register front-end for PRESENT: operand capture, start pulse,
// busy/done tracking, ciphertext latch and level interrupt.
module present_avalon_regs
    import present_pkg::*;
#(
    parameter logic [31:0] ID_VALUE    = 32'h5052_4553,
    parameter int          IRQ_SUPPORT = 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [3:0]         avs_address,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    input  logic               avs_read,
    output logic [31:0]        avs_readdata,
    output logic               irq,
    output logic               start,
    input  logic               eoc,
    output logic [BLOCK_W-1:0] plaintext,
    output logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] ciphertext
);

    logic [BLOCK_W-1:0] ct_reg;
    logic               busy, done, irq_en, irq_pend;
    logic               wr_ctrl, go, fin, clr;
    logic [31:0]        rdata;

    assign wr_ctrl = avs_write && (avs_address == REG_CTRL);
    assign go      = wr_ctrl && avs_writedata[CTRL_START] && !busy;
    assign clr     = wr_ctrl && avs_writedata[CTRL_IRQ_CLR];
    assign fin     = eoc && busy;

    always_comb begin
        rdata = '0;
        case (avs_address)
            REG_CTRL:    rdata = {29'b0, irq_en, 2'b0};
            REG_STATUS:  rdata = {29'b0, irq_pend, done, busy};
            REG_PT_LO:   rdata = plaintext[31:0];
            REG_PT_HI:   rdata = plaintext[63:32];
            REG_KEY_LO:  rdata = key[31:0];
            REG_KEY_MID: rdata = key[63:32];
            REG_KEY_HI:  rdata = {16'b0, key[79:64]};
            REG_CT_LO:   rdata = ct_reg[31:0];
            REG_CT_HI:   rdata = ct_reg[63:32];
            REG_ID:      rdata = ID_VALUE;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            avs_readdata <= '0;
            irq          <= 1'b0;
            start        <= 1'b0;
            plaintext    <= '0;
            key          <= '0;
            ct_reg       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            irq_en       <= 1'b0;
            irq_pend     <= 1'b0;
        end else begin
            // read sees pre-write state when a write shares the cycle
            if (avs_read)
                avs_readdata <= rdata;
            irq   <= irq_pend && irq_en;
            start <= go;
            if (avs_write && !busy) begin
                case (avs_address)
                    REG_PT_LO:   plaintext[31:0]  <= avs_writedata;
                    REG_PT_HI:   plaintext[63:32] <= avs_writedata;
                    REG_KEY_LO:  key[31:0]        <= avs_writedata;
                    REG_KEY_MID: key[63:32]       <= avs_writedata;
                    REG_KEY_HI:  key[79:64]       <= avs_writedata[15:0];
                    default: ;
                endcase
            end
            if (wr_ctrl)
                irq_en <= (IRQ_SUPPORT != 0) && avs_writedata[CTRL_IRQ_EN];
            if (go) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                irq_pend <= 1'b0;
            end else if (clr) begin
                irq_pend <= 1'b0;
            end
            // completion comes last so it wins over a coincident IRQ_CLR
            if (fin) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                irq_pend <= 1'b1;
                ct_reg   <= ciphertext;
            end
        end
    end

endmodule

// File: tb/tb_present_avalon_regs.sv
// Randomised and directed bench for present_avalon_regs with a word-level
// register model and a PRESENT-80 reference standing in for the datapath.
module tb_present_avalon_regs;
    import present_pkg::*;

    localparam logic [31:0] ID = 32'h5052_4553;
    localparam int N_CYC = N_ROUNDS / ROUNDS_PER_CYCLE;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        irq, start;
    logic        eoc = 1'b0;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic [63:0] ciphertext = '0;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_eoc = 0;
    bit env_auto = 1'b1;

    always #5 clk = ~clk;

    present_avalon_regs dut (
        .clk(clk), .nrst(nrst), .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
        .irq(irq), .start(start), .eoc(eoc), .plaintext(plaintext), .key(key),
        .ciphertext(ciphertext)
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // ---------------- PRESENT-80 reference ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        int i;
        tbl = 64'hC56B90AD3EF84712;
        i = int'(x);
        return tbl[63-4*i -: 4];
    endfunction

    function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] k);
        logic [63:0] s, t;
        logic [79:0] kk;
        logic [4:0]  rc;
        s = pt;
        kk = k;
        for (int r = 1; r <= 31; r++) begin
            s ^= kk[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
            t = '0;
            for (int i = 0; i < 63; i++) t[(i*16) % 63] = s[i];
            t[63] = s[63];
            s = t;
            kk = {kk[18:0], kk[79:19]};
            kk[79:76] = sbox(kk[79:76]);
            rc = 5'(r);
            kk[19:15] ^= rc;
        end
        return s ^ kk[79:16];
    endfunction

    // ---------------- register-level model ----------------
    logic [31:0] mreg [16];
    logic        m_busy, m_done, m_pend, m_en, m_start, m_irq;
    logic [63:0] m_ct;
    logic [31:0] m_rd;

    function automatic logic [31:0] m_view(input logic [3:0] a);
        case (a)
            4'd0: return {29'b0, m_en, 2'b0};
            4'd1: return {29'b0, m_pend, m_done, m_busy};
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6: return mreg[a];
            4'd7: return m_ct[31:0];
            4'd8: return m_ct[63:32];
            4'd9: return ID;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 16; i++) mreg[i] <= '0;
            {m_busy, m_done, m_pend, m_en, m_start, m_irq} <= '0;
            m_ct <= '0;
            m_rd <= '0;
        end else begin
            if (avs_read) m_rd <= m_view(avs_address);
            m_irq   <= m_pend & m_en;
            m_start <= 1'b0;
            if (avs_write && !m_busy && avs_address >= 4'd2 && avs_address <= 4'd6)
                mreg[avs_address] <= (avs_address == 4'd6) ? {16'b0, avs_writedata[15:0]} : avs_writedata;
            if (avs_write && avs_address == 4'd0) begin
                m_en <= avs_writedata[1];
                if (avs_writedata[0] && !m_busy) begin
                    m_start <= 1'b1; m_busy <= 1'b1; m_done <= 1'b0; m_pend <= 1'b0;
                end else if (avs_writedata[2]) m_pend <= 1'b0;
            end
            if (eoc && m_busy) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_pend <= 1'b1; m_ct <= ciphertext;
            end
        end
    end

    // compare every cycle, away from the active edge
    initial forever begin
        @(negedge clk);
        chk("start", 80'(start), 80'(m_start));
        chk("irq", 80'(irq), 80'(m_irq));
        chk("readdata", 80'(avs_readdata), 80'(m_rd));
        chk("plaintext", 80'(plaintext), 80'({mreg[3], mreg[2]}));
        chk("key", key, {mreg[6][15:0], mreg[5], mreg[4]});
        if (start) n_start++;
    end

    // stand-in for round controller + datapath
    initial begin : env
        int cnt;
        logic [63:0] res;
        cnt = 0;
        res = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                cnt = 0;
                eoc = 1'b0;
            end else if (env_auto) begin
                if (eoc) eoc = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        eoc = 1'b1;
                        ciphertext = res;
                        n_eoc++;
                    end
                end
                if (start) begin
                    cnt = N_CYC;
                    res = present_enc(plaintext, key);
                end
            end
        end
    end

    // ---------------- bus tasks (enter and leave at a negedge) ----------------
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        v = avs_readdata;
    endtask

    task automatic load(input logic [63:0] pt, input logic [79:0] k);
        wr(REG_PT_LO, pt[31:0]);
        wr(REG_PT_HI, pt[63:32]);
        wr(REG_KEY_LO, k[31:0]);
        wr(REG_KEY_MID, k[63:32]);
        wr(REG_KEY_HI, {16'hA5A5, k[79:64]});
    endtask

    task automatic wait_done(input string nm);
        logic [31:0] v;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            rd(REG_STATUS, v);
            ok = v[1];
        end
        if (!ok) chk({nm, "_timeout"}, 80'(0), 80'(1));
    endtask

    task automatic read_ct(output logic [63:0] ct);
        logic [31:0] lo, hi;
        rd(REG_CT_LO, lo);
        rd(REG_CT_HI, hi);
        ct = {hi, lo};
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [63:0] ct, pt_save;
        int s0, e0;

        chk("ref_zero", 80'(present_enc(64'h0, 80'h0)), 80'(64'h5579C138_7B228445));
        chk("ref_ones", 80'(present_enc(64'hFFFFFFFF_FFFFFFFF, {80{1'b1}})), 80'(64'h3333DCD3_213210D2));

        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // reset readback of the whole map
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), v);
            chk($sformatf("rst_rd%0d", a), 80'(v), (a == 9) ? 80'(ID) : 80'(0));
        end

        // all-zero vector with interrupt enabled
        load(64'h0, 80'h0);
        s0 = n_start;
        wr(REG_CTRL, 32'h3);
        wait_done("t2");
        chk("t2_starts", 80'(n_start - s0), 80'(1));
        read_ct(ct);
        chk("t2_ct", 80'(ct), 80'(64'h5579C138_7B228445));
        rd(REG_STATUS, v);
        chk("t2_status", 80'(v), 80'(32'h6));
        chk("t2_irq", 80'(irq), 80'(1));

        // all-ones vector
        load(64'hFFFFFFFF_FFFFFFFF, {80{1'b1}});
        rd(REG_KEY_HI, v);
        chk("t3_keyhi", 80'(v), 80'(32'h0000FFFF));
        wr(REG_CTRL, 32'h3);
        wait_done("t3");
        read_ct(ct);
        chk("t3_ct", 80'(ct), 80'(64'h3333DCD3_213210D2));

        // writes and START while busy are dropped
        load(64'h01234567_89ABCDEF, 80'h0);
        pt_save = plaintext;
        s0 = n_start; e0 = n_eoc;
        wr(REG_CTRL, 32'h3);
        wr(REG_PT_LO, 32'hDEADBEEF);
        wr(REG_CTRL, 32'h3);
        chk("t4_pt", 80'(plaintext), 80'(64'h01234567_89ABCDEF));
        wait_done("t4");
        repeat (40) @(negedge clk);
        chk("t4_starts", 80'(n_start - s0), 80'(1));
        chk("t4_eocs", 80'(n_eoc - e0), 80'(1));
        read_ct(ct);
        chk("t4_ct", 80'(ct), 80'(present_enc(pt_save, 80'h0)));

        // IRQ_CLR coincident with eoc: set wins
        env_auto = 1'b0;
        wr(REG_CTRL, 32'h3);
        repeat (4) @(negedge clk);
        eoc = 1'b1; ciphertext = 64'hCAFEF00D_12345678;
        wr(REG_CTRL, 32'h6);
        eoc = 1'b0;
        rd(REG_STATUS, v);
        chk("t5_status", 80'(v), 80'(32'h6));
        chk("t5_irq_hold", 80'(irq), 80'(1));
        read_ct(ct);
        chk("t5_ct", 80'(ct), 80'(64'hCAFEF00D_12345678));
        wr(REG_CTRL, 32'h6);
        @(negedge clk);
        chk("t5_irq_clr", 80'(irq), 80'(0));
        env_auto = 1'b1;
        @(negedge clk);
        wr(REG_CTRL, 32'h1);
        wait_done("t5b");
        repeat (4) @(negedge clk);
        chk("t5_irq_dis", 80'(irq), 80'(0));
        rd(REG_STATUS, v);
        chk("t5b_status", 80'(v), 80'(32'h6));

        // reset around round 10
        load(64'h0, 80'h0);
        wr(REG_CTRL, 32'h3);
        repeat (10) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("t6_start", 80'(start), 80'(0));
        chk("t6_irq", 80'(irq), 80'(0));
        chk("t6_rd", 80'(avs_readdata), 80'(0));
        chk("t6_pt_key", 80'(plaintext) | key, 80'(0));
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        rd(REG_STATUS, v);
        chk("t6_status", 80'(v), 80'(0));
        repeat (30) @(negedge clk);
        chk("t6_no_done", 80'(m_done | dut.done), 80'(0));
        load(64'h0, 80'h0);
        wr(REG_CTRL, 32'h3);
        wait_done("t6");
        read_ct(ct);
        chk("t6_ct", 80'(ct), 80'(64'h5579C138_7B228445));

        // random traffic, model compare runs every cycle
        for (int i = 0; i < 1500; i++) begin
            avs_address   = 4'($urandom_range(0, 15));
            avs_writedata = $urandom;
            if (avs_address == REG_CTRL && ($urandom_range(0, 3) != 0))
                avs_writedata[0] = 1'b0;
            avs_write = ($urandom_range(0, 3) == 0);
            avs_read  = ($urandom_range(0, 1) == 0);
            @(negedge clk);
        end
        avs_write = 1'b0;
        avs_read  = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/present_avalon_regs.md
Name: present_avalon_regs

Overview:
- Avalon-MM slave register front-end for the PRESENT accelerator. It sits directly upstream of the round controller and datapath.
- Captures the 64-bit plaintext and 80-bit key from the CPU and issues a one-cycle start pulse to the controller.
- Tracks busy/done, latches the ciphertext on eoc, and raises a level interrupt.

Parameters:
- ID_VALUE, 32'h5052_4553, constant returned by the ID register.
- IRQ_SUPPORT, 1, 0 ties irq low and makes IRQ_EN read as 0.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- avs_address  in  4  word address
- avs_write  in  1  write strobe, one cycle per access
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, registered, read latency 1
- irq  out  1  level interrupt to CPU
- start  out  1  one-cycle pulse to round controller
- eoc  in  1  one-cycle end-of-computation from round controller
- plaintext  out  64  operand to datapath, held stable while busy
- key  out  80  key to key schedule, held stable while busy
- ciphertext  in  64  datapath result, valid in the eoc cycle

Behaviour:
- Reset is asynchronous on nrst low and clears all state: start=0, irq=0, avs_readdata=0, plaintext=0, key=0, ct_reg=0, busy=0, done=0, irq_en=0, irq_pend=0.
- Address map (word addresses):
  - 0 CTRL (W): b0 START, b1 IRQ_EN (stored), b2 IRQ_CLR (write-1). Reads return {29'b0, irq_en, 2'b0}.
  - 1 STATUS (R): {29'b0, irq_pend, done, busy}.
  - 2 PT_LO, 3 PT_HI: plaintext[31:0], plaintext[63:32].
  - 4 KEY_LO, 5 KEY_MID, 6 KEY_HI: key[31:0], key[63:32], key[79:64] from writedata[15:0]. KEY_HI reads zero-extended.
  - 7 CT_LO, 8 CT_HI: ct_reg, read-only.
  - 9 ID: ID_VALUE.
  - 10-15: reserved. Read 0, writes ignored.
- Writes to STATUS, CT and ID are ignored.
- Writes to PT/KEY registers while busy=1 are dropped; operands never change mid-computation.
- Start:
  - A CTRL write with b0=1 while busy=0 sets start=1 on the next edge for exactly one cycle.
  - The same edge sets busy=1 and clears done and irq_pend.
  - START while busy=1 is ignored silently; no pulse is issued.
- Completion:
  - eoc=1 clears busy, sets done=1 and irq_pend=1, and loads ct_reg<=ciphertext on the same edge.
  - eoc while busy=0 is ignored.
- IRQ:
  - irq = irq_pend & irq_en, registered (one cycle after irq_pend/irq_en change).
  - IRQ_CLR clears irq_pend.
  - IRQ_CLR in the same cycle as eoc: set wins, irq_pend=1.
  - IRQ_EN/IRQ_CLR bits in a START write are honoured together with the start.
- Reads: avs_readdata is updated on the edge after avs_read=1. When avs_read=0 it holds its previous value.
- Read and write in the same cycle: Avalon forbids it; the write takes effect and the read returns the pre-write value.
- STATUS read in the eoc cycle returns busy=1, done=0; the new values are visible from the next access.
- Reset mid-computation: all state clears and any in-flight eoc is lost. The controller shares nrst.

Decomposition:
- present_pkg additions:
  - address localparams REG_CTRL..REG_ID
  - CTRL bit indices
  - KEY_W=80, BLOCK_W=64
- Existing present_pkg constants N_ROUNDS and ROUNDS_PER_CYCLE are used by the bench only.
- No sub-module. The block is a flat register file plus busy/done/irq logic.
- Top level instantiates it beside present_ctrl and the datapath.

Test Plan:
1. Reset then read every address 0-15 → 0 everywhere except addr 9 = 32'h5052_4553, each data one cycle after avs_read.
2. Write PT=0, KEY=0, CTRL=3 with bench driving present_ctrl and datapath (or model) → start pulse 1 cycle; busy=1 until eoc; CT_HI:CT_LO = 64'h5579C138_7B228445; STATUS=3'b110 (irq_pend, done); irq=1.
3. Key all-ones (KEY_HI=16'hFFFF), PT=64'hFFFFFFFF_FFFFFFFF, START → CT = 64'h3333DCD3_213210D2.
4. While busy: write PT_LO=32'hDEADBEEF and CTRL START again → plaintext unchanged, no second start pulse, exactly one eoc/done.
5. Force IRQ_CLR write in same cycle as eoc → irq_pend=1, irq stays high. A later IRQ_CLR → irq low on the following cycle. IRQ_EN=0 → irq never asserts despite done.
6. Assert nrst low mid-computation (round 10) → all outputs 0, busy=0, done=0; a subsequent full run returns the correct ciphertext.
